// File: rtl/alu_port_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// The selected request drives the ALU; outputs land in a one-entry response slot.
module alu_port_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int OPC_WIDTH   = 5,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   reset,

  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [DATA_WIDTH-1:0]  req0_operandA,
  input  logic [DATA_WIDTH-1:0]  req0_operandB,
  input  logic [OPC_WIDTH-1:0]   req0_ALUopcode,
  input  logic [SHAMT_WIDTH-1:0] req0_shiftamt,

  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [DATA_WIDTH-1:0]  req1_operandA,
  input  logic [DATA_WIDTH-1:0]  req1_operandB,
  input  logic [OPC_WIDTH-1:0]   req1_ALUopcode,
  input  logic [SHAMT_WIDTH-1:0] req1_shiftamt,

  output logic [DATA_WIDTH-1:0]  alu_operandA,
  output logic [DATA_WIDTH-1:0]  alu_operandB,
  output logic [OPC_WIDTH-1:0]   alu_ALUopcode,
  output logic [SHAMT_WIDTH-1:0] alu_shiftamt,
  input  logic [DATA_WIDTH-1:0]  alu_result,
  input  logic                   alu_isNotEqual,
  input  logic                   alu_isLessThan,
  input  logic                   alu_overflow,

  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_id,
  output logic [DATA_WIDTH-1:0]  resp_result,
  output logic                   resp_isNotEqual,
  output logic                   resp_isLessThan,
  output logic                   resp_overflow
);

  logic prio;
  logic grantValid;
  logic grantId;
  logic acceptOk;
  logic accept;

  // A lone requester always wins; prio only breaks ties.
  always_comb begin
    grantValid = req0_valid | req1_valid;
    grantId    = (req0_valid & req1_valid) ? prio : req1_valid;
    acceptOk   = ~resp_valid | resp_ready;
    req0_ready = acceptOk & grantValid & ~grantId & ~reset;
    req1_ready = acceptOk & grantValid & grantId & ~reset;
    accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  end

  // ALU is driven from the grant alone so the result is ready even under backpressure.
  always_comb begin
    alu_operandA  = '0;
    alu_operandB  = '0;
    alu_ALUopcode = '0;
    alu_shiftamt  = '0;
    if (grantValid) begin
      if (grantId) begin
        alu_operandA  = req1_operandA;
        alu_operandB  = req1_operandB;
        alu_ALUopcode = req1_ALUopcode;
        alu_shiftamt  = req1_shiftamt;
      end else begin
        alu_operandA  = req0_operandA;
        alu_operandB  = req0_operandB;
        alu_ALUopcode = req0_ALUopcode;
        alu_shiftamt  = req0_shiftamt;
      end
    end
  end

  // Accept overrides drain, so a simultaneous drain+accept leaves no bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      prio            <= 1'b0;
      resp_valid      <= 1'b0;
      resp_id         <= 1'b0;
      resp_result     <= '0;
      resp_isNotEqual <= 1'b0;
      resp_isLessThan <= 1'b0;
      resp_overflow   <= 1'b0;
    end else if (accept) begin
      prio            <= ~grantId;
      resp_valid      <= 1'b1;
      resp_id         <= grantId;
      resp_result     <= alu_result;
      resp_isNotEqual <= alu_isNotEqual;
      resp_isLessThan <= alu_isLessThan;
      resp_overflow   <= alu_overflow;
    end else if (resp_valid & resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_port_arbiter.sv
// Testbench for alu_port_arbiter: a behavioural ALU stands in for the real one,
// and a transaction-level model of the arbiter predicts every output.
module tb_alu_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_operandA, req0_operandB, req1_operandA, req1_operandB;
  logic [4:0]  req0_ALUopcode, req0_shiftamt, req1_ALUopcode, req1_shiftamt;
  logic [31:0] alu_operandA, alu_operandB, alu_result;
  logic [4:0]  alu_ALUopcode, alu_shiftamt;
  logic        alu_isNotEqual, alu_isLessThan, alu_overflow;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_result;
  logic        resp_isNotEqual, resp_isLessThan, resp_overflow;

  int checks = 0;
  int errors = 0;

  // Model state: the response slot as the consumer should see it.
  logic        mPrio;
  logic        mValid;
  logic        mId;
  logic [34:0] mData;
  logic        acc0, acc1;

  alu_port_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_operandA(req0_operandA), .req0_operandB(req0_operandB),
    .req0_ALUopcode(req0_ALUopcode), .req0_shiftamt(req0_shiftamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_operandA(req1_operandA), .req1_operandB(req1_operandB),
    .req1_ALUopcode(req1_ALUopcode), .req1_shiftamt(req1_shiftamt),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_ALUopcode(alu_ALUopcode), .alu_shiftamt(alu_shiftamt),
    .alu_result(alu_result), .alu_isNotEqual(alu_isNotEqual),
    .alu_isLessThan(alu_isLessThan), .alu_overflow(alu_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_isNotEqual(resp_isNotEqual),
    .resp_isLessThan(resp_isLessThan), .resp_overflow(resp_overflow)
  );

  always #5 clock = ~clock;

  // Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra; packs {result, ne, lt, ovf}.
  function automatic logic [34:0] aluRef(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    logic        ovf;
    ovf = 1'b0;
    case (op)
      5'd0: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd1: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a << sh;
      5'd5: r = $unsigned($signed(a) >>> sh);
      default: r = 32'd0;
    endcase
    return {r, a != b, $signed(a) < $signed(b), ovf};
  endfunction

  always_comb {alu_result, alu_isNotEqual, alu_isLessThan, alu_overflow} =
    aluRef(alu_ALUopcode, alu_operandA, alu_operandB, alu_shiftamt);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: check the handshake/ALU drive, clock it, then check the slot.
  task automatic applyStimulus();
    int          winner;
    logic        okAccept;
    logic [31:0] eA, eB;
    logic [4:0]  eOp, eSh;
    #2;
    if (req0_valid && req1_valid) winner = int'(mPrio);
    else if (req0_valid)          winner = 0;
    else if (req1_valid)          winner = 1;
    else                          winner = -1;
    okAccept = !mValid || resp_ready;
    acc0 = !reset && okAccept && (winner == 0);
    acc1 = !reset && okAccept && (winner == 1);
    eA = 0; eB = 0; eOp = 0; eSh = 0;
    if (winner == 0) begin
      eA = req0_operandA; eB = req0_operandB; eOp = req0_ALUopcode; eSh = req0_shiftamt;
    end else if (winner == 1) begin
      eA = req1_operandA; eB = req1_operandB; eOp = req1_ALUopcode; eSh = req1_shiftamt;
    end
    checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, acc0});
    checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, acc1});
    checkOutput("alu_operandA", alu_operandA, eA);
    checkOutput("alu_operandB", alu_operandB, eB);
    checkOutput("alu_ALUopcode", {27'd0, alu_ALUopcode}, {27'd0, eOp});
    checkOutput("alu_shiftamt", {27'd0, alu_shiftamt}, {27'd0, eSh});
    @(posedge clock);
    #1;
    if (reset) begin
      mPrio = 0; mValid = 0; mId = 0; mData = '0;
    end else if (acc0 || acc1) begin
      mValid = 1;
      mId    = acc1;
      mPrio  = !acc1;
      mData  = aluRef(eOp, eA, eB, eSh);
    end else if (mValid && resp_ready) begin
      mValid = 0;
    end
    checkOutput("resp_valid", {31'd0, resp_valid}, {31'd0, mValid});
    checkOutput("resp_id", {31'd0, resp_id}, {31'd0, mId});
    checkOutput("resp_result", resp_result, mData[34:3]);
    checkOutput("resp_flags", {29'd0, resp_isNotEqual, resp_isLessThan, resp_overflow},
                {29'd0, mData[2:0]});
  endtask

  task automatic setReq0(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic [4:0] sh);
    req0_valid = v; req0_operandA = a; req0_operandB = b; req0_ALUopcode = op; req0_shiftamt = sh;
  endtask

  task automatic setReq1(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic [4:0] sh);
    req1_valid = v; req1_operandA = a; req1_operandB = b; req1_ALUopcode = op; req1_shiftamt = sh;
  endtask

  initial begin
    mPrio = 0; mValid = 0; mId = 0; mData = '0; acc0 = 0; acc1 = 0;
    reset = 1; resp_ready = 1;
    setReq0(0, 0, 0, 0, 0);
    setReq1(0, 0, 0, 0, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("resetValid", {31'd0, resp_valid}, 32'd0);
    reset = 0;

    // Lone add 5+7 from requester 0.
    setReq0(1, 32'd5, 32'd7, 5'd0, 5'd0);
    applyStimulus();
    checkOutput("addResult", resp_result, 32'd12);
    checkOutput("addId", {31'd0, resp_id}, 32'd0);
    checkOutput("addFlags", {29'd0, resp_isNotEqual, resp_isLessThan, resp_overflow}, 32'b110);
    setReq0(0, 0, 0, 0, 0);
    applyStimulus();

    // Both requesters continuously valid after a reset: grants alternate from 0.
    reset = 1;
    applyStimulus();
    reset = 0;
    setReq0(1, 32'd3, 32'd9, 5'd1, 5'd0);
    setReq1(1, 32'd1, 32'd0, 5'd4, 5'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("altId", {31'd0, resp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      checkOutput("altResult", resp_result, (i % 2 == 0) ? 32'hFFFFFFFA : 32'h00000010);
    end
    setReq0(0, 0, 0, 0, 0);
    setReq1(0, 0, 0, 0, 0);
    applyStimulus();

    // Overflowing add, then three cycles of backpressure with req1 waiting.
    setReq0(1, 32'h7FFFFFFF, 32'd1, 5'd0, 5'd0);
    applyStimulus();
    setReq0(0, 0, 0, 0, 0);
    setReq1(1, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd2, 5'd0);
    resp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("holdResult", resp_result, 32'h80000000);
      checkOutput("holdOvf", {31'd0, resp_overflow}, 32'd1);
    end
    resp_ready = 1;
    applyStimulus();
    checkOutput("releaseId", {31'd0, resp_id}, 32'd1);
    checkOutput("releaseResult", resp_result, 32'h00F000F0);

    // Lone requester 1 streams back-to-back.
    for (int i = 0; i < 5; i++) begin
      setReq1(1, $urandom, $urandom, 5'($urandom_range(0, 5)), 5'($urandom));
      applyStimulus();
      checkOutput("streamValid", {31'd0, resp_valid}, 32'd1);
      checkOutput("streamId", {31'd0, resp_id}, 32'd1);
    end

    // Reset with a full slot and both requests pending.
    setReq0(1, 32'd10, 32'd20, 5'd0, 5'd0);
    setReq1(1, 32'd30, 32'd40, 5'd3, 5'd0);
    reset = 1;
    applyStimulus();
    checkOutput("rstValid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rstResult", resp_result, 32'd0);
    reset = 0;
    applyStimulus();
    checkOutput("rstTieId", {31'd0, resp_id}, 32'd0);
    checkOutput("rstTieResult", resp_result, 32'd30);

    // Idle: ALU drive zero and the slot drains.
    setReq0(0, 32'hDEADBEEF, 32'hCAFEF00D, 5'd3, 5'd7);
    setReq1(0, 32'h12345678, 32'h9ABCDEF0, 5'd1, 5'd9);
    applyStimulus();
    checkOutput("idleOperandA", alu_operandA, 32'd0);
    checkOutput("idleDrain", {31'd0, resp_valid}, 32'd0);

    // Random traffic; unaccepted requests stay put, new ones are drawn fresh.
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 500; i++) begin
      if (!(req0_valid && !acc0))
        setReq0(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 6)), 5'($urandom));
      if (!(req1_valid && !acc1))
        setReq1(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 6)), 5'($urandom));
      resp_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 59) == 0);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
